// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_t : controller FSM states (IDLE, RUN, DONE)
//   SLICE_W : width of the single carry-lookahead slice, in bits
package serial_add_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle between a requester and the serial adder controller.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (y, cout)
//   busy                : controller is stepping through nibbles
// Modports: master = requester/consumer side, slave = controller side.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, y, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, y, cout, busy
  );

endinterface : serial_add_ctrl_if

// File: rtl/serial_add_ctrl_cla4.sv
// 4-bit carry-lookahead adder, purely combinational.
//   a, b : 4-bit addends     cin  : carry in
//   y    : 4-bit sum         cout : carry out of bit 3
// Every carry is expanded from generate/propagate terms so no carry
// ripples through a previous sum bit.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] y,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign y    = p ^ c[3:0];
  assign cout = c[4];

endmodule : cla4

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder controller: one 4-bit CLA slice processes a
// WIDTH-bit add one nibble per cycle, LSB nibble first.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of serial_add_ctrl_if (operand handshake,
//                result handshake, busy)
// Result appears NIBBLES edges after the accepting edge and is held
// until the consumer takes it; no new operand is accepted meanwhile.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0]                idx;
  logic                            carry;
  logic [NIBBLES-1:0][SLICE_W-1:0] op_a;
  logic [NIBBLES-1:0][SLICE_W-1:0] op_b;
  logic [NIBBLES-1:0][SLICE_W-1:0] result;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_y;
  logic               slice_cout;
  logic               last_nibble;

  assign last_nibble = (idx == IDX_W'(NIBBLES - 1));

  // Operand nibble selected by comparing the index against each slot.
  always_comb begin
    // NOTE: defaults first so every path assigns; otherwise a latch is inferred.
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        slice_a = op_a[i];
        slice_b = op_b[i];
      end
    end
  end

  cla4 u_cla4 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_nibble) next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset explicitly because a reset
  // must leave y and cout at zero, not at whatever the last add produced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= bus.cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) result[i] <= slice_y;
          end
          carry <= slice_cout;
          // Index parks on the top nibble instead of wrapping.
          if (!last_nibble) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.y    = result;
  assign bus.cout = carry;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes a+b+cin into a
// queue, an independent monitor compares whenever out_valid is shown.
module tb_serial_add_ctrl;

  localparam int W  = 16;
  localparam int NB = W / 4;

  typedef struct {
    logic [W-1:0] y;
    logic         cout;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   ready_mode = 1;   // 0 random, 1 always high, 2 held low
  bit   seen = 1'b0;
  exp_t sb[$];

  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'($urandom_range(0, 1));
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares presented results with the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      seen = 1'b0;
    end else begin
      if (bus.busy) check("in_ready_in_run", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid) begin
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          if (!seen) begin
            check("latency", 32'(cyc - sb[0].acc), 32'(NB));
            seen = 1'b1;
          end
          check("y", 32'(bus.y), 32'(sb[0].y));
          check("cout", 32'(bus.cout), 32'(sb[0].cout));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  // Wait for in_ready, present operands for one accepting edge, push the
  // expected sum. With scramble set, in_valid stays high and a/b/cin keep
  // changing through the whole RUN phase.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input bit scramble);
    logic [W:0] sum;
    exp_t       e;
    int         n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 100);
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.a = av;
    bus.b = bv;
    bus.cin = cv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    sum    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    e.y    = sum[W-1:0];
    e.cout = sum[W];
    e.acc  = cyc;
    sb.push_back(e);
    if (scramble) begin
      repeat (NB) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.cin = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.in_ready) return;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus4.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Carry through every nibble.
    ready_mode = 1;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_drain();

    // Stalled consumer: result must stay put for 5 cycles.
    ready_mode = 2;
    issue(16'h1234, 16'h4321, 1'b1, 1'b0);
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (5) @(negedge clk);
    ready_mode = 1;
    wait_drain();

    // All ones with carry in.
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_drain();

    // Operands wiggling during RUN must not leak into the result.
    for (int i = 0; i < 4; i++) issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    wait_drain();

    // Reset in the second RUN cycle abandons the operation.
    issue(16'h7777, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_y", 32'(bus.y), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
    end
    issue(16'h0005, 16'h0003, 1'b0, 1'b0);
    wait_drain();

    // Random traffic with a random consumer.
    ready_mode = 0;
    for (int i = 0; i < 3000; i++) issue(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    ready_mode = 1;
    wait_drain();

    // Single-nibble build: result one edge after accept.
    @(negedge clk);
    bus4.a = 4'hF; bus4.b = 4'h1; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    check("w4_busy", 32'(bus4.busy), 32'd1);
    check("w4_not_yet_valid", 32'(bus4.out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("w4_out_valid", 32'(bus4.out_valid), 32'd1);
    check("w4_y", 32'(bus4.y), 32'h0);
    check("w4_cout", 32'(bus4.cout), 32'd1);
    @(negedge clk);
    check("w4_valid_dropped", 32'(bus4.out_valid), 32'd0);
    check("w4_in_ready", 32'(bus4.in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_serial_add_ctrl
